// File: rtl/lvl_pkg.sv
// Level constants and thermometer decode for the pump-controller front end.
// Shared with the pump controller so both sides agree on the level codes.
package lvl_pkg;

  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] lvl_code_t;

  localparam lvl_code_t L0   = 3'd0;
  localparam lvl_code_t L25  = 3'd1;
  localparam lvl_code_t L50  = 3'd2;
  localparam lvl_code_t L75  = 3'd3;
  localparam lvl_code_t L100 = 3'd4;

  localparam logic [3:0] THERM_0   = 4'b0000;
  localparam logic [3:0] THERM_25  = 4'b0001;
  localparam logic [3:0] THERM_50  = 4'b0011;
  localparam logic [3:0] THERM_75  = 4'b0111;
  localparam logic [3:0] THERM_100 = 4'b1111;

  typedef struct packed {
    logic      ok;
    lvl_code_t code;
  } lvl_dec_t;

  function automatic lvl_dec_t therm_decode(
    input logic [3:0] p
  );
    lvl_dec_t r;
    r.ok   = 1'b1;
    r.code = L0;
    unique case (1'b1)
      (p == THERM_0):   r.code = L0;
      (p == THERM_25):  r.code = L25;
      (p == THERM_50):  r.code = L50;
      (p == THERM_75):  r.code = L75;
      (p == THERM_100): r.code = L100;
      default:          r.ok   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/level_sensor_conditioner_if.sv
// Switch inputs and conditioned level outputs of level_sensor_conditioner.
// slave is the conditioner side, master the switch/controller side.
interface level_sensor_conditioner_if;
  import lvl_pkg::*;

  logic [3:0] sw_inf;
  logic [3:0] sw_sup;
  lvl_code_t  lvl_inf_code;
  lvl_code_t  lvl_sup_code;
  logic       fault_inf;
  logic       fault_sup;
  logic       lvl_valid;
  logic       lvl_chg;

  modport master (
    output sw_inf, sw_sup,
    input  lvl_inf_code, lvl_sup_code,
    input  fault_inf, fault_sup,
    input  lvl_valid, lvl_chg
  );

  modport slave (
    input  sw_inf, sw_sup,
    output lvl_inf_code, lvl_sup_code,
    output fault_inf, fault_sup,
    output lvl_valid, lvl_chg
  );

endinterface

// File: rtl/level_sensor_conditioner_switch_debouncer.sv
// One float switch: 2-FF synchronizer followed by a hold-time debouncer.
// The debounced state flips after DEBOUNCE_CYCLES differing synced samples.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_async,
  output logic sw_db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw_async;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_db = state_q;

endmodule

// File: rtl/level_sensor_conditioner.sv
// Float-switch conditioner: sync, debounce, thermometer encode, fault flag.
// Define LVL_FAULT_LATCH_EN to make fault_inf/fault_sup sticky until rst.
module level_sensor_conditioner
  import lvl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  level_sensor_conditioner_if.slave  bus
);

  localparam int unsigned ST_MAX = DEBOUNCE_CYCLES + 2;
  localparam int unsigned ST_W   = $clog2(ST_MAX + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(ST_MAX);

  logic [7:0] sw_raw;
  logic [7:0] sw_db;

  assign sw_raw = {bus.sw_sup, bus.sw_inf};

  for (genvar i = 0; i < 8; i++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .sw_async (sw_raw[i]),
      .sw_db    (sw_db[i])
    );
  end

  lvl_dec_t  dec_inf, dec_sup;
  lvl_code_t inf_q, inf_d;
  lvl_code_t sup_q, sup_d;
  logic      finf_q, finf_d;
  logic      fsup_q, fsup_d;
  logic      chg_q, chg_d;
  logic      valid_q, valid_d;
  logic [ST_W-1:0] st_q, st_d;

  always_comb begin
    dec_inf = therm_decode(sw_db[3:0]);
    dec_sup = therm_decode(sw_db[7:4]);
    inf_d   = dec_inf.ok ? dec_inf.code : inf_q;
    sup_d   = dec_sup.ok ? dec_sup.code : sup_q;
`ifdef LVL_FAULT_LATCH_EN
    finf_d  = finf_q | ~dec_inf.ok;
    fsup_d  = fsup_q | ~dec_sup.ok;
`else
    finf_d  = ~dec_inf.ok;
    fsup_d  = ~dec_sup.ok;
`endif
    chg_d   = (inf_d != inf_q) | (sup_d != sup_q);
    // valid lands on the same edge as the first stable code load
    st_d    = (st_q == ST_LAST) ? st_q : st_q + 1'b1;
    valid_d = valid_q | (st_q == ST_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inf_q   <= L0;
      sup_q   <= L0;
      finf_q  <= 1'b0;
      fsup_q  <= 1'b0;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
      st_q    <= '0;
    end else begin
      inf_q   <= inf_d;
      sup_q   <= sup_d;
      finf_q  <= finf_d;
      fsup_q  <= fsup_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
      st_q    <= st_d;
    end
  end

  assign bus.lvl_inf_code = inf_q;
  assign bus.lvl_sup_code = sup_q;
  assign bus.fault_inf    = finf_q;
  assign bus.fault_sup    = fsup_q;
  assign bus.lvl_valid    = valid_q;
  assign bus.lvl_chg      = chg_q;

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner with DEBOUNCE_CYCLES=4.
// Expected values are hand-derived edge counts from the input change.
module tb_level_sensor_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   chg_cnt = 0;

  level_sensor_conditioner_if bus ();

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.lvl_chg) chg_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // after this the next posedge is edge 1 of the held inputs
  task automatic do_reset(input logic [3:0] inf,
                          input logic [3:0] sup);
    rst = 1'b1;
    bus.sw_inf = inf;
    bus.sw_sup = sup;
    steps(2);
    rst = 1'b0;
    chg_cnt = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sw_inf = 4'b1111;
    bus.sw_sup = 4'b1111;
    steps(2);
    chk("rst_inf_code", int'(bus.lvl_inf_code), 0);
    chk("rst_sup_code", int'(bus.lvl_sup_code), 0);
    chk("rst_fault_inf", int'(bus.fault_inf), 0);
    chk("rst_fault_sup", int'(bus.fault_sup), 0);
    chk("rst_valid", int'(bus.lvl_valid), 0);
    chk("rst_chg", int'(bus.lvl_chg), 0);
  endtask

  task automatic test_startup();
    do_reset(4'b0111, 4'b0000);
    steps(6);
    chk("start_e6_code", int'(bus.lvl_inf_code), 0);
    chk("start_e6_valid", int'(bus.lvl_valid), 0);
    step();
    chk("start_e7_code", int'(bus.lvl_inf_code), 3);
    chk("start_e7_valid", int'(bus.lvl_valid), 1);
    steps(6);
    chk("start_sup_code", int'(bus.lvl_sup_code), 0);
    chk("start_chg_pulses", chg_cnt, 1);
    chk("start_valid_hold", int'(bus.lvl_valid), 1);
  endtask

  task automatic test_glitch();
    do_reset(4'b0000, 4'b0011);
    steps(10);
    chk("glitch_base", int'(bus.lvl_sup_code), 2);
    chg_cnt = 0;
    bus.sw_sup = 4'b0111;
    steps(3);
    bus.sw_sup = 4'b0011;
    steps(10);
    chk("glitch_code", int'(bus.lvl_sup_code), 2);
    chk("glitch_chg", chg_cnt, 0);
    bus.sw_sup = 4'b0111;
    steps(6);
    chk("hold_e6", int'(bus.lvl_sup_code), 2);
    step();
    chk("hold_e7", int'(bus.lvl_sup_code), 3);
    steps(4);
    chk("hold_chg", chg_cnt, 1);
  endtask

  task automatic test_fault();
    int exp_f;
    do_reset(4'b0011, 4'b0000);
    steps(10);
    chk("fault_base", int'(bus.lvl_inf_code), 2);
    chg_cnt = 0;
    bus.sw_inf = 4'b0101;
    steps(6);
    chk("fault_e6", int'(bus.fault_inf), 0);
    step();
    chk("fault_e7", int'(bus.fault_inf), 1);
    chk("fault_code_hold", int'(bus.lvl_inf_code), 2);
    chk("fault_sup_clean", int'(bus.fault_sup), 0);
    steps(3);
    bus.sw_inf = 4'b0011;
    steps(6);
    chk("fault_restore_e6", int'(bus.fault_inf), 1);
    step();
`ifdef LVL_FAULT_LATCH_EN
    exp_f = 1;
`else
    exp_f = 0;
`endif
    chk("fault_restore_e7", int'(bus.fault_inf), exp_f);
    chk("fault_code_after", int'(bus.lvl_inf_code), 2);
    chk("fault_chg", chg_cnt, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fault_rst_clear", int'(bus.fault_inf), 0);
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0001, 4'b1111);
    steps(10);
    chk("b2b_base_inf", int'(bus.lvl_inf_code), 1);
    chk("b2b_base_sup", int'(bus.lvl_sup_code), 4);
    chg_cnt = 0;
    bus.sw_inf = 4'b1111;
    bus.sw_sup = 4'b0000;
    steps(6);
    chk("b2b_e6_inf", int'(bus.lvl_inf_code), 1);
    chk("b2b_e6_sup", int'(bus.lvl_sup_code), 4);
    step();
    chk("b2b_e7_inf", int'(bus.lvl_inf_code), 4);
    chk("b2b_e7_sup", int'(bus.lvl_sup_code), 0);
    chk("b2b_e7_chg", int'(bus.lvl_chg), 1);
    steps(5);
    chk("b2b_chg_pulses", chg_cnt, 1);
  endtask

  task automatic test_mid_reset();
    do_reset(4'b0011, 4'b0000);
    steps(10);
    chk("mid_base", int'(bus.lvl_inf_code), 2);
    bus.sw_inf = 4'b1111;
    steps(4);
    rst = 1'b1;
    step();
    chk("mid_rst_code", int'(bus.lvl_inf_code), 0);
    chk("mid_rst_valid", int'(bus.lvl_valid), 0);
    chk("mid_rst_chg", int'(bus.lvl_chg), 0);
    rst = 1'b0;
    steps(6);
    chk("mid_e6", int'(bus.lvl_inf_code), 0);
    step();
    chk("mid_e7", int'(bus.lvl_inf_code), 4);
    chk("mid_e7_valid", int'(bus.lvl_valid), 1);
  endtask

  task automatic test_bubble();
    do_reset(4'b1000, 4'b0000);
    steps(6);
    chk("bub_e6_fault", int'(bus.fault_inf), 0);
    step();
    chk("bub_e7_fault", int'(bus.fault_inf), 1);
    chk("bub_code", int'(bus.lvl_inf_code), 0);
    steps(3);
    chk("bub_chg", chg_cnt, 0);
  endtask

  initial begin
    bus.sw_inf = 4'b0000;
    bus.sw_sup = 4'b0000;
    test_reset();
    test_startup();
    test_glitch();
    test_fault();
    test_back_to_back();
    test_mid_reset();
    test_bubble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_sensor_conditioner.md
# level_sensor_conditioner

Front-end stage for the pump controller. It conditions the two tanks' raw float-switch inputs and produces the 3-bit level codes (0–4) the controller consumes on `lvl_inf_raw`/`lvl_sup_raw`. Per switch, the block synchronizes, debounces, thermometer-to-binary encodes, and flags invalid (bubble) patterns. All outputs reset to the safe code 0, and the pump controller never starts on code 0.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive cycles a synchronized switch must hold a new value before it is accepted (1 ms at 50 MHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `sw_inf`  in  4  lower-tank float switches, asynchronous; bit k=1 means wet at (k+1)·25 %.
- `sw_sup`  in  4  upper-tank float switches, same encoding.
- `lvl_inf_code`  out  3  conditioned lower-tank level 0–4; connects to the controller's `lvl_inf_raw`.
- `lvl_sup_code`  out  3  conditioned upper-tank level 0–4; connects to the controller's `lvl_sup_raw`.
- `fault_inf`  out  1  lower-tank debounced pattern is not a thermometer code.
- `fault_sup`  out  1  upper-tank debounced pattern is not a thermometer code.
- `lvl_valid`  out  1  high once the startup debounce window has elapsed after reset.
- `lvl_chg`  out  1  one-cycle pulse when either code register changes value.

## Operation
- Each of the 8 switches passes through a 2-FF synchronizer, then a debouncer.
- Debouncer:
  - Holds a debounced state and a counter.
  - If the synced sample equals the state, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, the state flips and the counter clears.
- Encoder, per tank, acting on the debounced 4-bit vector:
  - 0000→0, 0001→1, 0011→2, 0111→3, 1111→4. All 11 other patterns are invalid.
  - On a valid pattern: the code register loads the value and the fault register clears.
  - On an invalid pattern: the code register holds its last valid value and the fault register sets.
- `lvl_chg` = registered OR of (new code ≠ old code) for both tanks. A simultaneous change on both tanks gives a single pulse.
- Startup counter:
  - Counts from reset release and saturates.
  - Sets `lvl_valid` at the edge where the code registers first reflect stable inputs; it stays 1 until `rst`.
  - Codes update regardless of `lvl_valid`.
- Reset values: all synchronizers, debounced states, counters, code registers 0; `fault_*` 0; `lvl_valid` 0; `lvl_chg` 0.

## Timing
- Clock edges below are counted from the edge at which a stable input change is first sampled (edge 1):
  - Sync stage 2 at edge 2.
  - Debounced state flips at edge 2+DEBOUNCE_CYCLES.
  - Code/fault registers update at edge 3+DEBOUNCE_CYCLES.
  - `lvl_chg` is high during the cycle after that update.
- Glitch rejection: any change shorter than DEBOUNCE_CYCLES synced cycles never reaches the code.
- `lvl_valid` rises at edge 3+DEBOUNCE_CYCLES after the first edge with `rst`=0.
- `rst` asserted mid-debounce: on that edge every register returns to its reset value; in-progress counts are discarded.
- Independent switches in one tank may settle on different edges. Transient bubble patterns during a legal level change are therefore possible and set `fault_*` for the affected cycles.
- Counter width is clog2(DEBOUNCE_CYCLES); the counter never wraps.

## Configuration
- `LVL_FAULT_LATCH_EN`
  - Defined: `fault_inf`/`fault_sup` are sticky. They clear only on `rst`, not on the return of a valid pattern. Codes still update on valid patterns.
  - Undefined: faults track the current debounced pattern as described above.

## Structure
- Shared package `lvl_pkg`:
  - Level constants L0..L100 (3'd0–3'd4).
  - The five legal thermometer patterns.
  - The 3-bit code width.
- The pump controller imports the same constants.
- Sub-module `switch_debouncer`: synchronizer + debounce counter for one bit, parameterized by DEBOUNCE_CYCLES; instantiated 8 times.
- Encoder, fault, startup and change logic live in the top level.

## Test plan
(DEBOUNCE_CYCLES=4 throughout)
- Reset, then `sw_inf`=0111 and `sw_sup`=0000 held → `lvl_inf_code`=3 at edge 7, `lvl_sup_code`=0, `lvl_valid`=1 at edge 7, exactly one `lvl_chg` pulse.
- From level 2 (`sw_sup`=0011): bit 2 pulses high for 3 cycles → `lvl_sup_code` stays 2 and no `lvl_chg`. Hold it 4+ cycles → code 3.
- `sw_inf` 0011→0101 → `fault_inf`=1 and code stays 2. Restore 0011 → `fault_inf`=0 after 7 edges (macro undefined). With `LVL_FAULT_LATCH_EN` defined, `fault_inf` stays 1 until `rst`.
- `sw_inf` 0001→1111 and `sw_sup` 1111→0000 on the same edge → both codes update on the same edge (4 and 0), a single `lvl_chg` pulse.
- `rst` asserted 2 cycles into a pending debounce with `sw_inf`=1111 → all outputs 0 next edge. After release, code 4 only at edge 7.
- Bubble 1000 with no prior valid level after reset → code stays 0, `fault_inf`=1.
